// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_pkg
// Description : Shared cache-subsystem definitions: default L2 address and
//               line geometry, the L1->L2 operation type and the L1/L2
//               arbiter state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;

    // Default L2 geometry, used as parameter defaults by cache blocks
    localparam int L2_TAG_W   = 18;
    localparam int L2_INDEX_W = 8;
    localparam int L2_LINE_W  = 512;

    typedef enum logic [0:0] {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

endpackage : cache_pkg
`default_nettype wire

// File: rtl/l1_l2_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Returns the first set bit
//               of req at or after position ptr, wrapping modulo N.
// Ports       : req [N-1:0]      request vector
//               ptr [IDX_W-1:0]  search start position (must be < N)
//               gnt [N-1:0]      one-hot grant, zero when no request
//               idx [IDX_W-1:0]  encoded grant position, zero when none
//               any              at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        int  w_k;
        logic w_found;
        gnt     = '0;
        idx     = '0;
        w_found = 1'b0;
        w_k     = 0;
        // Walk the N positions starting at ptr; the first requester wins
        for (int i = 0; i < N; i++) begin
            w_k = int'(ptr) + i;
            if (w_k >= N) begin
                w_k = w_k - N;
            end
            if (!w_found && req[w_k]) begin
                w_found  = 1'b1;
                gnt[w_k] = 1'b1;
                idx      = w_k[IDX_W-1:0];
            end
        end
    end

    assign any = |req;

endmodule : rr_pick
`default_nettype wire

// File: rtl/l1_l2_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : l1_l2_arbiter
// Description : N-channel round-robin arbiter between the L1 caches and the
//               shared L2 request port. One transaction in flight at a time;
//               the grant is locked until L2 signals ready, which is routed
//               back only to the owning channel. Payload is not registered:
//               requesters hold request and payload until their ready_o.
// Ports       : clk, nrst (async, active-low)
//               read_i/write_i [N_REQ]         per-channel requests
//               tag_i/index_i                  per-channel read address
//               write_tag_i/write_index_i      per-channel write-back address
//               write_data_i                   per-channel write-back line
//               ready_o [N_REQ]                completion pulse to owner
//               read_L1_L2/write_L1_L2         L2 request strobes
//               tag_L1_L2/index_L1_L2          muxed L2 address
//               write_data_L1_L2               muxed write-back line
//               ready_L2_L1                    L2 completion pulse
//               busy_o, grant_o [N_REQ]        status
// Config      : L1L2_ARB_WB_PRIO_EN - when defined, pending write-backs are
//               arbitrated ahead of all reads.
// Revision    : 1.0 - initial release
// ============================================================================
module l1_l2_arbiter
    import cache_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int TAG_W   = L2_TAG_W,
    parameter int INDEX_W = L2_INDEX_W,
    parameter int LINE_W  = L2_LINE_W
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic [N_REQ-1:0]           read_i,
    input  logic [N_REQ-1:0]           write_i,
    input  logic [N_REQ*TAG_W-1:0]     tag_i,
    input  logic [N_REQ*INDEX_W-1:0]   index_i,
    input  logic [N_REQ*TAG_W-1:0]     write_tag_i,
    input  logic [N_REQ*INDEX_W-1:0]   write_index_i,
    input  logic [N_REQ*LINE_W-1:0]    write_data_i,
    output logic [N_REQ-1:0]           ready_o,
    output logic                       read_L1_L2,
    output logic                       write_L1_L2,
    output logic [TAG_W-1:0]           tag_L1_L2,
    output logic [INDEX_W-1:0]         index_L1_L2,
    output logic [LINE_W-1:0]          write_data_L1_L2,
    input  logic                       ready_L2_L1,
    output logic                       busy_o,
    output logic [N_REQ-1:0]           grant_o
);

    localparam int                 IDX_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [IDX_W-1:0]   C_LAST_IDX = IDX_W'(N_REQ - 1);

    arb_state_e         r_state;
    arb_state_e         w_state_nxt;
    op_e                r_op;
    logic [IDX_W-1:0]   r_gnt_idx;
    logic [IDX_W-1:0]   r_rr_ptr;

    logic [N_REQ-1:0]   w_req_all;
    logic [N_REQ-1:0]   w_arb_req;
    logic [N_REQ-1:0]   w_pick_gnt;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_pick_any;
    logic               w_done;
    int                 w_own;

    assign w_req_all = read_i | write_i;

`ifdef L1L2_ARB_WB_PRIO_EN
    // Any pending write-back masks out all read-only requesters
    assign w_arb_req = (|write_i) ? write_i : w_req_all;
`else
    assign w_arb_req = w_req_all;
`endif

    rr_pick #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req (w_arb_req),
        .ptr (r_rr_ptr),
        .gnt (w_pick_gnt),
        .idx (w_pick_idx),
        .any (w_pick_any)
    );

    assign w_done = (r_state == ARB_BUSY) && ready_L2_L1;
    assign w_own  = int'(r_gnt_idx);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Owner, operation and round-robin pointer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_gnt_idx <= '0;
            r_op      <= OP_READ;
            r_rr_ptr  <= '0;
        end else begin
            if ((r_state == ARB_IDLE) && w_pick_any) begin
                r_gnt_idx <= w_pick_idx;
                // A channel requesting both is serviced as a write first;
                // its read stays asserted and re-arbitrates afterwards.
                r_op      <= (|(w_pick_gnt & write_i)) ? OP_WRITE : OP_READ;
            end
            if (w_done) begin
                r_rr_ptr <= (r_gnt_idx == C_LAST_IDX) ? '0 : r_gnt_idx + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs. Outputs are decoded from state only, so an
    // asynchronous reset clears them immediately.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        ready_o          = '0;
        read_L1_L2       = 1'b0;
        write_L1_L2      = 1'b0;
        tag_L1_L2        = '0;
        index_L1_L2      = '0;
        write_data_L1_L2 = '0;
        busy_o           = 1'b0;
        grant_o          = '0;

        case (r_state)
            ARB_IDLE: begin
                if (w_pick_any) begin
                    w_state_nxt = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                busy_o           = 1'b1;
                grant_o[w_own]   = 1'b1;
                read_L1_L2       = (r_op == OP_READ);
                write_L1_L2      = (r_op == OP_WRITE);
                write_data_L1_L2 = write_data_i[w_own*LINE_W +: LINE_W];
                if (r_op == OP_WRITE) begin
                    tag_L1_L2   = write_tag_i[w_own*TAG_W +: TAG_W];
                    index_L1_L2 = write_index_i[w_own*INDEX_W +: INDEX_W];
                end else begin
                    tag_L1_L2   = tag_i[w_own*TAG_W +: TAG_W];
                    index_L1_L2 = index_i[w_own*INDEX_W +: INDEX_W];
                end
                if (ready_L2_L1) begin
                    ready_o[w_own] = 1'b1;
                    w_state_nxt    = ARB_IDLE;
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
            end
        endcase
    end

endmodule : l1_l2_arbiter
`default_nettype wire
